// File: rtl/dm_cache_if.sv
// Purpose : memory-side bus of dm_cache (line command, write data, fill response).
// Latency : none, wires only.
// Backpressure: req_valid/req_ready and req_data_valid/req_data_ready handshakes; resp has no ready.
// Ports   : master = cache (issues commands and write data), slave = main memory.
interface dm_cache_if;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/dm_cache.sv
// Purpose : blocking write-back, write-allocate direct-mapped cache, 16-byte lines, flop array.
// Latency : hit data in the cycle after acceptance; miss = LOOKUP + [WB] + FILL_REQ + FILL_WAIT.
// Backpressure: o_stall high during a miss; WB and fill wait on the memory ready handshakes.
// Ports   : i_clk/i_reset (sync, active high); i_cpu_addr/re/we/din and o_cpu_dout/o_stall
//           toward the CPU; mem (dm_cache_if.master) toward main memory.
module dm_cache #(
  parameter int LINES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cpu_addr,
  input  logic        i_cpu_re,
  input  logic [3:0]  i_cpu_we,
  input  logic [31:0] i_cpu_din,
  output logic [31:0] o_cpu_dout,
  output logic        o_stall,
  dm_cache_if.master  mem
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL_REQ, S_FILL_WAIT, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:2]        r_addr;
  logic [3:0]         r_we;
  logic [31:0]        r_din;
  logic [31:0]        r_dout;
  logic [31:0]        r_fill_word;
  logic               r_cmd_done;
  logic               r_dat_done;
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TW-1:0]      r_tag  [LINES];
  logic [127:0]       r_data [LINES];

  logic [IW-1:0]      w_idx;
  logic [1:0]         w_off;
  logic [TW-1:0]      w_tag;
  logic [127:0]       w_line;
  logic               w_hit;
  logic               w_store;
  logic               w_store_hit;
  logic               w_fill;
  logic               w_accept;
  logic               w_cmd_fire;
  logic               w_dat_fire;
  logic [31:0]        w_dout;
  logic               w_unused_addr;

  // Byte lane merge of a store word into a line.
  function automatic logic [127:0] f_merge(input logic [127:0] line, input logic [1:0] off,
                                           input logic [3:0] we, input logic [31:0] din);
    logic [127:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) res[32*int'(off) + 8*b +: 8] = din[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] f_word(input logic [127:0] line, input logic [1:0] off);
    return line[32*int'(off) +: 32];
  endfunction

  assign w_unused_addr = ^i_cpu_addr[1:0];

  assign w_idx   = r_addr[IW+3:4];
  assign w_off   = r_addr[3:2];
  assign w_tag   = r_addr[31:IW+4];
  assign w_line  = r_data[w_idx];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_store = |r_we;

  assign w_store_hit = (r_state == S_LOOKUP) && w_hit && w_store;
  assign w_fill      = (r_state == S_FILL_WAIT) && mem.mem_resp_valid;
  assign w_cmd_fire  = mem.mem_req_valid && mem.mem_req_ready;
  assign w_dat_fire  = mem.mem_req_data_valid && mem.mem_req_data_ready;

  // Next state and outputs.
  always_comb begin
    w_state_nxt            = r_state;
    o_stall                = 1'b0;
    mem.mem_req_valid      = 1'b0;
    mem.mem_req_rw         = 1'b0;
    mem.mem_req_addr       = r_addr[31:4];
    mem.mem_req_data_valid = 1'b0;
    mem.mem_req_data_bits  = w_line;
    mem.mem_req_data_mask  = 16'hFFFF;
    w_dout                 = r_dout;

    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          w_dout = f_word(w_line, w_off);
        end else begin
          o_stall     = 1'b1;
          w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL_REQ;
        end
      end
      S_WB: begin
        o_stall                = 1'b1;
        mem.mem_req_valid      = !r_cmd_done;
        mem.mem_req_rw         = 1'b1;
        mem.mem_req_addr       = {r_tag[w_idx], w_idx};
        mem.mem_req_data_valid = !r_dat_done;
        if ((r_cmd_done || w_cmd_fire) && (r_dat_done || w_dat_fire))
          w_state_nxt = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        o_stall           = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) w_state_nxt = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        o_stall = 1'b1;
        if (mem.mem_resp_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Pre-merge word captured with the fill; the array already holds any store merge.
        w_dout = r_fill_word;
      end
      default: ;
    endcase

    w_accept = !o_stall && (i_cpu_re || (i_cpu_we != 4'b0000));
    if (r_state == S_IDLE || r_state == S_DONE || (r_state == S_LOOKUP && w_hit))
      w_state_nxt = w_accept ? S_LOOKUP : S_IDLE;
  end

  assign o_cpu_dout = w_dout;

  // Control state, line status bits and held output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_dout     <= 32'h0;
      r_cmd_done <= 1'b0;
      r_dat_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= w_dout;
      if (w_accept) begin
        r_addr <= i_cpu_addr[31:2];
        r_we   <= i_cpu_we;
        r_din  <= i_cpu_din;
      end
      // Handshake tracking only matters inside WB; clear it everywhere else.
      if (r_state == S_WB) begin
        if (w_cmd_fire) r_cmd_done <= 1'b1;
        if (w_dat_fire) r_dat_done <= 1'b1;
      end else begin
        r_cmd_done <= 1'b0;
        r_dat_done <= 1'b0;
      end
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= w_store;
      end else if (w_store_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data array, not reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_fill) begin
        r_data[w_idx] <= w_store ? f_merge(mem.mem_resp_data, w_off, r_we, r_din)
                                 : mem.mem_resp_data;
        r_tag[w_idx]  <= w_tag;
        r_fill_word   <= f_word(mem.mem_resp_data, w_off);
      end else if (w_store_hit) begin
        r_data[w_idx] <= f_merge(w_line, w_off, r_we, r_din);
      end
    end
  end
endmodule

// File: tb/tb_dm_cache.sv
module tb_dm_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;

  dm_cache_if mem ();

  dm_cache #(.LINES(64)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cpu_addr (cpu_addr),
    .i_cpu_re   (cpu_re),
    .i_cpu_we   (cpu_we),
    .i_cpu_din  (cpu_din),
    .o_cpu_dout (cpu_dout),
    .o_stall    (stall),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] L1   = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
  localparam logic [127:0] L1M  = {32'h33333333, 32'h22222222, 32'h11115678, 32'hDEADBEEF};
  localparam logic [127:0] L2   = {32'h44444444, 32'h44444444, 32'h44444444, 32'hCAFEF00D};
  localparam logic [127:0] L3   = {32'h40404043, 32'h40404042, 32'h40404041, 32'h40404040};
  localparam logic [127:0] L4   = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
  localparam logic [127:0] L4M  = {32'h0D0D0D0D, 32'hAB0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
  localparam logic [127:0] L5   = {32'h0, 32'h0, 32'h0, 32'h55555555};
  localparam logic [127:0] JUNK = {4{32'hBADBAD00}};

  int checks = 0;
  int errors = 0;

  logic         cmd_rw_q   [$];
  logic [27:0]  cmd_addr_q [$];
  logic [127:0] wdat_q     [$];

  // Record every memory handshake that fires.
  always @(posedge clk) begin
    if (mem.mem_req_valid === 1'b1 && mem.mem_req_ready === 1'b1) begin
      cmd_rw_q.push_back(mem.mem_req_rw);
      cmd_addr_q.push_back(mem.mem_req_addr);
    end
    if (mem.mem_req_data_valid === 1'b1 && mem.mem_req_data_ready === 1'b1)
      wdat_q.push_back(mem.mem_req_data_bits);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 32'h0; cpu_re = 1'b0; cpu_we = 4'b0; cpu_din = 32'h0;
    mem.mem_req_ready = 1'b0; mem.mem_req_data_ready = 1'b0;
    mem.mem_resp_valid = 1'b0; mem.mem_resp_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_stall", stall, 1'b0);
    chk("rst_dout", cpu_dout, 32'h0);
    chk("rst_req_valid", mem.mem_req_valid, 1'b0);
    chk("rst_data_valid", mem.mem_req_data_valid, 1'b0);

    // Cold load miss of 0x1000.
    cpu_addr = 32'h1000; cpu_re = 1'b1;
    tick();
    chk("t1_lookup_stall", stall, 1'b1);
    mem.mem_req_ready = 1'b1;
    tick();
    chk("t1_fill_valid", mem.mem_req_valid, 1'b1);
    chk("t1_fill_rw", mem.mem_req_rw, 1'b0);
    chk("t1_fill_addr", mem.mem_req_addr, 28'h100);
    chk("t1_mask", mem.mem_req_data_mask, 16'hFFFF);
    tick();
    chk("t1_wait_valid", mem.mem_req_valid, 1'b0);
    chk("t1_wait_stall", stall, 1'b1);
    mem.mem_resp_valid = 1'b1; mem.mem_resp_data = L1;
    tick();
    mem.mem_resp_valid = 1'b0;
    chk("t1_done_stall", stall, 1'b0);
    chk("t1_done_dout", cpu_dout, 32'hDEADBEEF);
    chk("t1_ncmd", cmd_addr_q.size(), 1);
    tick();
    chk("t1_hit_stall", stall, 1'b0);
    chk("t1_hit_dout", cpu_dout, 32'hDEADBEEF);

    // Store hit to 0x1004 then load of the same word on the next edge.
    cpu_addr = 32'h1004; cpu_re = 1'b0; cpu_we = 4'b0011; cpu_din = 32'h12345678;
    tick();
    chk("t2_store_stall", stall, 1'b0);
    chk("t2_store_dout", cpu_dout, 32'h11111111);
    cpu_we = 4'b0; cpu_re = 1'b1;
    tick();
    chk("t2_load_stall", stall, 1'b0);
    chk("t2_load_dout", cpu_dout, 32'h11115678);
    cpu_re = 1'b0;
    tick();
    chk("t2_hold_dout", cpu_dout, 32'h11115678);
    chk("t2_ncmd", cmd_addr_q.size(), 1);

    // Dirty conflict miss 0x2000 with write-data back-pressure.
    cpu_addr = 32'h2000; cpu_re = 1'b1;
    tick();
    chk("t3_lookup_stall", stall, 1'b1);
    mem.mem_req_ready = 1'b1; mem.mem_req_data_ready = 1'b0;
    tick();
    chk("t3_wb_valid", mem.mem_req_valid, 1'b1);
    chk("t3_wb_rw", mem.mem_req_rw, 1'b1);
    chk("t3_wb_addr", mem.mem_req_addr, 28'h100);
    chk("t3_wb_dvalid1", mem.mem_req_data_valid, 1'b1);
    chk("t3_wb_bits", mem.mem_req_data_bits, L1M);
    tick();
    chk("t3_wb_valid_drop", mem.mem_req_valid, 1'b0);
    chk("t3_wb_dvalid2", mem.mem_req_data_valid, 1'b1);
    tick();
    chk("t3_wb_dvalid3", mem.mem_req_data_valid, 1'b1);
    tick();
    chk("t3_wb_dvalid4", mem.mem_req_data_valid, 1'b1);
    chk("t3_wb_noreq4", mem.mem_req_valid, 1'b0);
    mem.mem_req_data_ready = 1'b1;
    tick();
    chk("t3_fill_valid", mem.mem_req_valid, 1'b1);
    chk("t3_fill_rw", mem.mem_req_rw, 1'b0);
    chk("t3_fill_addr", mem.mem_req_addr, 28'h200);
    chk("t3_fill_dvalid", mem.mem_req_data_valid, 1'b0);
    tick();
    chk("t3_wait_stall", stall, 1'b1);
    mem.mem_resp_valid = 1'b1; mem.mem_resp_data = L2;
    tick();
    mem.mem_resp_valid = 1'b0; cpu_re = 1'b0;
    chk("t3_done_stall", stall, 1'b0);
    chk("t3_done_dout", cpu_dout, 32'hCAFEF00D);
    chk("t3_ncmd", cmd_addr_q.size(), 3);
    chk("t3_cmd1_rw", cmd_rw_q[1], 1'b1);
    chk("t3_cmd1_addr", cmd_addr_q[1], 28'h100);
    chk("t3_cmd2_rw", cmd_rw_q[2], 1'b0);
    chk("t3_cmd2_addr", cmd_addr_q[2], 28'h200);
    chk("t3_wdat", wdat_q[0], L1M);
    tick();

    // Reset during FILL_WAIT, then a stray response.
    cpu_addr = 32'h4000; cpu_re = 1'b1;
    tick();
    chk("t4_lookup_stall", stall, 1'b1);
    tick();
    tick();
    reset = 1'b1; cpu_re = 1'b0;
    tick();
    reset = 1'b0;
    chk("t4_rst_stall", stall, 1'b0);
    chk("t4_rst_req_valid", mem.mem_req_valid, 1'b0);
    chk("t4_rst_dout", cpu_dout, 32'h0);
    mem.mem_resp_valid = 1'b1; mem.mem_resp_data = JUNK;
    tick();
    mem.mem_resp_valid = 1'b0;
    chk("t4_stray_stall", stall, 1'b0);
    chk("t4_stray_dout", cpu_dout, 32'h0);
    cpu_re = 1'b1;
    tick();
    chk("t4_remiss_stall", stall, 1'b1);
    tick();
    chk("t4_fill_addr", mem.mem_req_addr, 28'h400);
    tick();
    mem.mem_resp_valid = 1'b1; mem.mem_resp_data = L3;
    tick();
    mem.mem_resp_valid = 1'b0; cpu_re = 1'b0;
    chk("t4_done_dout", cpu_dout, 32'h40404040);
    chk("t4_ncmd", cmd_addr_q.size(), 5);
    tick();

    // Store miss to 0x3008, then a conflicting miss writes it back.
    cpu_addr = 32'h3008; cpu_we = 4'b1000; cpu_din = 32'hAB000000;
    tick();
    chk("t5_lookup_stall", stall, 1'b1);
    tick();
    chk("t5_fill_rw", mem.mem_req_rw, 1'b0);
    chk("t5_fill_addr", mem.mem_req_addr, 28'h300);
    tick();
    mem.mem_resp_valid = 1'b1; mem.mem_resp_data = L4;
    tick();
    mem.mem_resp_valid = 1'b0; cpu_we = 4'b0;
    chk("t5_done_stall", stall, 1'b0);
    chk("t5_done_dout", cpu_dout, 32'h0C0C0C0C);
    tick();
    cpu_re = 1'b1;
    tick();
    chk("t5_hit_stall", stall, 1'b0);
    chk("t5_hit_dout", cpu_dout, 32'hAB0C0C0C);
    cpu_addr = 32'h5000;
    tick();
    chk("t5_conflict_stall", stall, 1'b1);
    tick();
    chk("t5_wb_rw", mem.mem_req_rw, 1'b1);
    chk("t5_wb_addr", mem.mem_req_addr, 28'h300);
    chk("t5_wb_bits", mem.mem_req_data_bits, L4M);
    tick();
    chk("t5_fill2_addr", mem.mem_req_addr, 28'h500);
    tick();
    mem.mem_resp_valid = 1'b1; mem.mem_resp_data = L5;
    tick();
    mem.mem_resp_valid = 1'b0; cpu_re = 1'b0;
    chk("t5_done2_dout", cpu_dout, 32'h55555555);
    chk("t5_ncmd", cmd_addr_q.size(), 8);
    chk("t5_nwdat", wdat_q.size(), 2);
    chk("t5_wdat", wdat_q[1], L4M);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
